branch_resolve: RTL

- Update-side partner of the branch lookup table. It drives the table's write, write_key, write_val and hit inputs.
- Holds a FIFO of predictions issued at fetch. It compares each one, in order, against the execute-stage outcome.
- Emits one table update per resolved branch. Emits a registered flush/redirect when a prediction was wrong.
- Sits between the fetch stage (which pushes predictions), the execute stage (which resolves branches) and the lookup table.

---
 rtl/branch_resolve.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
//   Update side of the branch lookup table. Fetch pushes each prediction it
//   issues into an in-order FIFO. Execute resolves the oldest outstanding
//   branch, and the head entry is compared against the actual outcome.
//   Every accepted resolve produces a one-cycle registered table update.
//   A wrong prediction does four things on the same edge: it clears the FIFO
//   (every younger entry is wrong-path), it drops any same-cycle push, it
//   raises a registered flush/redirect pulse, and it holds the block in DRAIN
//   for FLUSH_CYCLES cycles.
//
// Ports
//   clk, reset                      clock (rising edge), async active-high reset
//   push, push_pc/taken/target      prediction issued by fetch
//   ready                           push accepted this cycle
//   resolve, resolve_pc/taken/target  outcome of the oldest branch from execute
//   write, write_key, write_val, hit  table update (registered, 1-cycle latency)
//   flush, flush_pc                 mispredict redirect (registered pulse)
//   count                           entries held
//   err                             sticky protocol error (overflow, underflow,
//                                   resolve PC not matching the head entry)
//
// Optional feature (macro BRANCH_RESOLVE_STATS_EN)
//   Adds saturating counters stat_branches and stat_mispredicts.
// ---------------------------------------------------------------------------
module branch_resolve #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DEPTH        = 8,
  parameter int DEPTH_LOG2   = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic                  push_taken,
  input  logic [ADDR_WIDTH-1:0] push_target,
  output logic                  ready,
  input  logic                  resolve,
  input  logic [ADDR_WIDTH-1:0] resolve_pc,
  input  logic                  resolve_taken,
  input  logic [ADDR_WIDTH-1:0] resolve_target,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] write_key,
  output logic [ADDR_WIDTH-1:0] write_val,
  output logic                  hit,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] flush_pc,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  err
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
`endif
);

  localparam logic [DEPTH_LOG2:0]   DEPTH_C    = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE     = ADDR_WIDTH'(1);
  // The counter is loaded with FLUSH_CYCLES-1 and DRAIN exits once it reads
  // zero, so DRAIN lasts exactly FLUSH_CYCLES cycles.
  localparam logic [3:0]            DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t state_q, state_d;
  logic [3:0] drain_q, drain_d;

  // Prediction storage (data only, no reset needed)
  logic [ADDR_WIDTH-1:0] fifo_pc     [DEPTH];
  logic                  fifo_taken  [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_target [DEPTH];

  logic [DEPTH_LOG2-1:0] rd_ptr_q, wr_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;

  logic                  in_run, not_empty;
  logic                  resolve_acc, mispredict, pop_p0, push_acc;
  logic                  pc_mismatch, err_set;
  logic [DEPTH_LOG2:0]   count_d;

  logic                  wr_vld_p1, hit_p1, flush_vld_p1, err_q;
  logic [ADDR_WIDTH-1:0] wr_key_p1, wr_val_p1, flush_pc_p1;

  // ---- stage p0: head compare and accept decisions ----
  assign in_run      = (state_q == RUN);
  assign not_empty   = (count_q != '0);
  assign resolve_acc = in_run && resolve && not_empty;
  assign pc_mismatch = (fifo_pc[rd_ptr_q] != resolve_pc);
  // Target only matters when the branch was actually taken.
  assign mispredict  = resolve_acc &&
                       (pc_mismatch ||
                        (fifo_taken[rd_ptr_q] != resolve_taken) ||
                        (resolve_taken && (fifo_target[rd_ptr_q] != resolve_target)));
  assign pop_p0      = resolve_acc && !mispredict;
  // A pop frees the head slot on the same edge, so a full FIFO can still
  // take a push alongside a correct resolve. Reset forces ready low.
  assign ready       = !reset && in_run && ((count_q < DEPTH_C) || pop_p0);
  // A push in the mispredict cycle is wrong-path and is dropped.
  assign push_acc    = push && ready && !mispredict;
  assign err_set     = in_run && ((push && !ready) ||
                                  (resolve && !not_empty) ||
                                  (resolve_acc && pc_mismatch));

  always_comb begin
    count_d = count_q;
    if (mispredict) begin
      count_d = '0;
    end else if (push_acc && !pop_p0) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_p0 && !push_acc) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      RUN: begin
        if (mispredict) begin
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (drain_q == 4'd0) begin
          state_d = RUN;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      drain_q <= 4'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      fifo_pc[wr_ptr_q]     <= push_pc;
      fifo_taken[wr_ptr_q]  <= push_taken;
      fifo_target[wr_ptr_q] <= push_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (err_set) begin
        err_q <= 1'b1;
      end
      if (mispredict) begin
        // Clearing means collapsing the read pointer onto the write pointer.
        rd_ptr_q <= wr_ptr_q;
      end else begin
        if (pop_p0) begin
          rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
        if (push_acc) begin
          wr_ptr_q <= wr_ptr_q + PTR_ONE;
        end
      end
    end
  end

  // ---- stage p1: registered table update and redirect ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_vld_p1    <= 1'b0;
      wr_key_p1    <= '0;
      wr_val_p1    <= '0;
      hit_p1       <= 1'b0;
      flush_vld_p1 <= 1'b0;
      flush_pc_p1  <= '0;
    end else begin
      wr_vld_p1    <= resolve_acc;
      flush_vld_p1 <= mispredict;
      if (resolve_acc) begin
        wr_key_p1 <= resolve_pc;
        wr_val_p1 <= resolve_target;
        hit_p1    <= resolve_taken;
      end
      if (mispredict) begin
        // Not-taken falls through to the next word; wraps at the top of memory.
        flush_pc_p1 <= resolve_taken ? resolve_target : (resolve_pc + PC_ONE);
      end
    end
  end

  assign write     = wr_vld_p1;
  assign write_key = wr_key_p1;
  assign write_val = wr_val_p1;
  assign hit       = hit_p1;
  assign flush     = flush_vld_p1;
  assign flush_pc  = flush_pc_p1;
  assign count     = count_q;
  assign err       = err_q;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (resolve_acc && (stat_br_q != '1)) begin
        stat_br_q <= stat_br_q + 32'd1;
      end
      if (mispredict && (stat_mp_q != '1)) begin
        stat_mp_q <= stat_mp_q + 32'd1;
      end
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule
